// File: rtl/deflection_router_pipe.sv
// Two-stage bufferless deflection router: stage 1 ejects/injects, stage 2 allocates output ports.
// Latency: link in -> eject 1 cycle, link in -> link out 2 cycles.
// Backpressure: none on links (every flit leaves); injection waits on inject_grant until a slot frees.
module deflection_router_pipe #(
    parameter int                FLIT_W      = 32,
    parameter int                ADDR_W      = 4,
    parameter int                SEQ_W       = 5,
    parameter logic [ADDR_W-1:0] ROUTER_ADDR = 4'h5,
    parameter int                EPOCH       = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] in_n,
    input  logic [FLIT_W-1:0] in_e,
    input  logic [FLIT_W-1:0] in_s,
    input  logic [FLIT_W-1:0] in_w,
    input  logic [FLIT_W-1:0] inject_flit,
    input  logic              inject_req,
    output logic              inject_grant,
    output logic [FLIT_W-1:0] out_n,
    output logic [FLIT_W-1:0] out_e,
    output logic [FLIT_W-1:0] out_s,
    output logic [FLIT_W-1:0] out_w,
    output logic [FLIT_W-1:0] eject_flit,
    output logic              eject_valid,
    output logic [ADDR_W-1:0] golden_id,
    output logic [15:0]       defl_cnt
);
    localparam int HALF    = ADDR_W / 2;
    localparam int CNT_W   = (EPOCH > 1) ? $clog2(EPOCH) : 1;
    localparam int SRC_LSB = 7;
    localparam int DST_LSB = 7 + ADDR_W;
    localparam int SEQ_LSB = 7 + 2 * ADDR_W;
    localparam int KEY_W   = 1 + SEQ_W;
    localparam int PRI_W   = KEY_W + 2;
    localparam logic [HALF-1:0] RX = ROUTER_ADDR[HALF-1:0];
    localparam logic [HALF-1:0] RY = ROUTER_ADDR[ADDR_W-1:HALF];

    typedef logic [FLIT_W-1:0] flit_t;

    logic [CNT_W-1:0]  epoch_cnt;
    flit_t             in_arr   [4];
    flit_t             in_g     [4];
    flit_t             slot_nxt [4];
    flit_t             slot_q   [4];
    flit_t             out_nxt  [4];
    flit_t             out_q    [4];
    flit_t             ej_nxt;
    logic              ej_hit;
    logic [1:0]        ej_idx;
    logic [KEY_W-1:0]  ej_key;
    logic              inj_ok;
    logic [1:0]        inj_idx;
    logic [ADDR_W-1:0] dst      [4];
    logic [3:0]        has_prod;
    logic [1:0]        prod     [4];
    logic [PRI_W-1:0]  pri      [4];
    logic [2:0]        rank     [4];
    logic [3:0]        free;
    logic [1:0]        port;
    logic [2:0]        defl_inc;
    logic [16:0]       defl_sum;

    assign in_arr[0] = in_n;
    assign in_arr[1] = in_e;
    assign in_arr[2] = in_s;
    assign in_arr[3] = in_w;

    // Stage 1: golden rewrite, ejection pick, then injection into the first hole left behind.
    always_comb begin
        ej_hit  = 1'b0;
        ej_idx  = '0;
        ej_key  = '0;
        ej_nxt  = '0;
        inj_ok  = 1'b0;
        inj_idx = '0;
        for (int p = 0; p < 4; p++) begin
            in_g[p] = '0;
            if (in_arr[p][1]) begin
                in_g[p]    = in_arr[p];
                in_g[p][0] = (in_arr[p][SRC_LSB +: ADDR_W] == golden_id);
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (in_g[p][1] && in_g[p][DST_LSB +: ADDR_W] == ROUTER_ADDR &&
                (!ej_hit || {in_g[p][0], ~in_g[p][SEQ_LSB +: SEQ_W]} > ej_key)) begin
                ej_hit = 1'b1;
                ej_idx = 2'(p);
                ej_key = {in_g[p][0], ~in_g[p][SEQ_LSB +: SEQ_W]};
            end
        end
        for (int p = 0; p < 4; p++) begin
            slot_nxt[p] = in_g[p];
            if (ej_hit && ej_idx == 2'(p)) begin
                ej_nxt       = in_g[p];
                ej_nxt[6:4]  = 3'd4;
                slot_nxt[p]  = '0;
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (!inj_ok && !slot_nxt[p][1]) begin
                inj_ok  = 1'b1;
                inj_idx = 2'(p);
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (inject_req && inj_ok && inj_idx == 2'(p)) begin
                slot_nxt[p]      = inject_flit;
                slot_nxt[p][1]   = 1'b1;
                slot_nxt[p][3:2] = 2'(p);
                slot_nxt[p][0]   = (inject_flit[SRC_LSB +: ADDR_W] == golden_id);
            end
        end
    end

    assign inject_grant = inject_req & inj_ok;

    // XY route; a flit addressed here that lost ejection has no productive port.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            dst[s]      = slot_q[s][DST_LSB +: ADDR_W];
            has_prod[s] = slot_q[s][1];
            prod[s]     = 2'd0;
            if (dst[s][HALF-1:0] > RX)             prod[s] = 2'd1;
            else if (dst[s][HALF-1:0] < RX)        prod[s] = 2'd3;
            else if (dst[s][ADDR_W-1:HALF] > RY)   prod[s] = 2'd2;
            else if (dst[s][ADDR_W-1:HALF] < RY)   prod[s] = 2'd0;
            else                                   has_prod[s] = 1'b0;
        end
    end

    // Rank = number of valid slots that outrank this one; slot index breaks all ties.
    always_comb begin
        for (int s = 0; s < 4; s++)
            pri[s] = {slot_q[s][0], ~slot_q[s][SEQ_LSB +: SEQ_W], ~2'(s)};
        for (int s = 0; s < 4; s++) begin
            rank[s] = '0;
            for (int o = 0; o < 4; o++)
                if (o != s && slot_q[o][1] && pri[o] > pri[s])
                    rank[s] = rank[s] + 3'd1;
        end
    end

    // Stage 2: allocate in rank order; losers take the lowest free port.
    always_comb begin
        free     = 4'hF;
        defl_inc = '0;
        port     = '0;
        for (int p = 0; p < 4; p++)
            out_nxt[p] = '0;
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < 4; s++) begin
                if (slot_q[s][1] && rank[s] == 3'(r)) begin
                    if (has_prod[s] && free[prod[s]]) begin
                        port = prod[s];
                    end else begin
                        for (int p = 3; p >= 0; p--)
                            if (free[p]) port = 2'(p);
                        if (has_prod[s]) defl_inc = defl_inc + 3'd1;
                    end
                    free[port]         = 1'b0;
                    out_nxt[port]      = slot_q[s];
                    out_nxt[port][6:4] = {1'b0, port};
                end
            end
        end
    end

    assign defl_sum = {1'b0, defl_cnt} + {14'd0, defl_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 4; p++) begin
                slot_q[p] <= '0;
                out_q[p]  <= '0;
            end
            eject_flit  <= '0;
            eject_valid <= 1'b0;
            golden_id   <= '0;
            epoch_cnt   <= '0;
            defl_cnt    <= '0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                slot_q[p] <= slot_nxt[p];
                out_q[p]  <= out_nxt[p];
            end
            eject_flit  <= ej_nxt;
            eject_valid <= ej_hit;
            defl_cnt    <= defl_sum[16] ? 16'hFFFF : defl_sum[15:0];
            if (epoch_cnt == CNT_W'(EPOCH - 1)) begin
                epoch_cnt <= '0;
                golden_id <= golden_id + ADDR_W'(1);
            end else begin
                epoch_cnt <= epoch_cnt + CNT_W'(1);
            end
        end
    end

    assign out_n = out_q[0];
    assign out_e = out_q[1];
    assign out_s = out_q[2];
    assign out_w = out_q[3];
endmodule

// File: tb/tb_deflection_router_pipe.sv
// Directed bench for deflection_router_pipe with a queue/sort based reference model.
`timescale 1ns/1ps
module tb_deflection_router_pipe;
    localparam int EP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_n, in_e, in_s, in_w, inject_flit;
    logic        inject_req;
    logic        inject_grant;
    logic [31:0] out_n, out_e, out_s, out_w, eject_flit;
    logic        eject_valid;
    logic [3:0]  golden_id;
    logic [15:0] defl_cnt;

    deflection_router_pipe #(
        .FLIT_W(32), .ADDR_W(4), .SEQ_W(5), .ROUTER_ADDR(4'h5), .EPOCH(EP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_n(in_n), .in_e(in_e), .in_s(in_s), .in_w(in_w),
        .inject_flit(inject_flit), .inject_req(inject_req), .inject_grant(inject_grant),
        .out_n(out_n), .out_e(out_e), .out_s(out_s), .out_w(out_w),
        .eject_flit(eject_flit), .eject_valid(eject_valid),
        .golden_id(golden_id), .defl_cnt(defl_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    function automatic logic [31:0] mk(input int src, input int dst, input int seq);
        logic [31:0] f;
        f        = '0;
        f[1]     = 1'b1;
        f[10:7]  = 4'(src);
        f[14:11] = 4'(dst);
        f[19:15] = 5'(seq);
        return f;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_slot [4];
    logic [31:0] m_out  [4];
    logic [31:0] m_ej;
    bit          m_ejv;
    int          m_defl, m_ep, m_gid;

    function automatic int score(input logic [31:0] f, input int idx);
        return (f[0] ? 1000 : 0) + 10 * (31 - int'(f[19:15])) + (3 - idx);
    endfunction

    // Router sits at x=1, y=1; -1 means no productive port.
    function automatic int want_port(input logic [31:0] f);
        int d, dx, dy;
        d  = int'(f[14:11]);
        dx = d % 4;
        dy = d / 4;
        if (dx > 1) return 1;
        if (dx < 1) return 3;
        if (dy > 1) return 2;
        if (dy < 1) return 0;
        return -1;
    endfunction

    // Grant iff flits remaining after ejection leave a hole.
    function automatic bit model_grant();
        int nv;
        bit mine;
        logic [31:0] fin [4];
        fin[0] = in_n; fin[1] = in_e; fin[2] = in_s; fin[3] = in_w;
        nv = 0;
        mine = 0;
        for (int p = 0; p < 4; p++) begin
            if (fin[p][1]) nv++;
            if (fin[p][1] && fin[p][14:11] == 4'd5) mine = 1;
        end
        return inject_req && (nv - (mine ? 1 : 0) < 4);
    endfunction

    function automatic void model_alloc();
        int ord [$];
        bit used [4];
        int w, p, tmp;
        for (int i = 0; i < 4; i++) begin
            m_out[i] = '0;
            used[i]  = 0;
        end
        for (int s = 0; s < 4; s++)
            if (m_slot[s][1]) ord.push_back(s);
        for (int i = 0; i < ord.size(); i++)
            for (int j = i + 1; j < ord.size(); j++)
                if (score(m_slot[ord[j]], ord[j]) > score(m_slot[ord[i]], ord[i])) begin
                    tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
                end
        for (int k = 0; k < ord.size(); k++) begin
            w = want_port(m_slot[ord[k]]);
            if (w >= 0 && !used[w]) begin
                p = w;
            end else begin
                p = 0;
                while (p < 3 && used[p]) p++;
                if (w >= 0) m_defl = (m_defl < 65535) ? m_defl + 1 : 65535;
            end
            used[p] = 1;
            m_out[p] = m_slot[ord[k]];
            m_out[p][6:4] = 3'(p);
        end
    endfunction

    function automatic void model_stage1();
        logic [31:0] fin [4];
        int best;
        bit done;
        fin[0] = in_n; fin[1] = in_e; fin[2] = in_s; fin[3] = in_w;
        best = -1;
        for (int p = 0; p < 4; p++) begin
            m_slot[p] = '0;
            if (fin[p][1]) begin
                m_slot[p] = fin[p];
                m_slot[p][0] = (int'(fin[p][10:7]) == m_gid);
            end
        end
        for (int p = 0; p < 4; p++)
            if (m_slot[p][1] && m_slot[p][14:11] == 4'd5 &&
                (best < 0 || score(m_slot[p], p) > score(m_slot[best], best)))
                best = p;
        m_ej = '0;
        m_ejv = 0;
        if (best >= 0) begin
            m_ej = m_slot[best];
            m_ej[6:4] = 3'd4;
            m_ejv = 1;
            m_slot[best] = '0;
        end
        done = 0;
        for (int p = 0; p < 4; p++)
            if (!done && inject_req && !m_slot[p][1]) begin
                done = 1;
                m_slot[p] = inject_flit;
                m_slot[p][1] = 1'b1;
                m_slot[p][3:2] = 2'(p);
                m_slot[p][0] = (int'(inject_flit[10:7]) == m_gid);
            end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 4; p++) begin
                m_slot[p] = '0;
                m_out[p]  = '0;
            end
            m_ej = '0; m_ejv = 0; m_defl = 0; m_ep = 0; m_gid = 0;
        end else begin
            model_alloc();
            model_stage1();
            m_ep++;
            if (m_ep == EP) begin
                m_ep = 0;
                m_gid = (m_gid + 1) % 16;
            end
        end
    end

    always @(negedge clk) begin
        chk("inject_grant", 32'(inject_grant), 32'(model_grant()));
        chk("out_n", out_n, m_out[0]);
        chk("out_e", out_e, m_out[1]);
        chk("out_s", out_s, m_out[2]);
        chk("out_w", out_w, m_out[3]);
        chk("eject_flit", eject_flit, m_ej);
        chk("eject_valid", 32'(eject_valid), 32'(m_ejv));
        chk("golden_id", 32'(golden_id), 32'(m_gid));
        chk("defl_cnt", 32'(defl_cnt), 32'(m_defl));
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_in();
        in_n = '0; in_e = '0; in_s = '0; in_w = '0;
        inject_flit = '0; inject_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_links", out_n | out_e | out_s | out_w, 32'h0);
        chk("rst_eject", eject_flit | 32'(eject_valid), 32'h0);
        chk("rst_golden_defl", 32'(golden_id) | 32'(defl_cnt), 32'h0);
        cyc(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        idle_in();
        #2 rst_n = 1'b0;
        cyc(2);
        chk("por_golden", 32'(golden_id), 32'h0);
        chk("por_eject_valid", 32'(eject_valid), 32'h0);
        rst_n = 1'b1;
        cyc(4);
        chk("epoch_golden_1", 32'(golden_id), 32'h1);
        cyc(4);
        chk("epoch_golden_2", 32'(golden_id), 32'h2);

        // Golden flit beats lower seq; loser deflects to out_n.
        do_reset();
        in_n = mk(0, 5, 3);
        in_e = mk(2, 5, 1);
        cyc();
        chk("ej_prio_valid", 32'(eject_valid), 32'h1);
        chk("ej_prio_flit", eject_flit, 32'h0001A843);
        idle_in();
        cyc();
        chk("ej_prio_loser_out_n", out_n, 32'h0000A902);

        // Lower seq wins, then equal seq falls back to lower port.
        do_reset();
        in_n = mk(3, 5, 3);
        in_e = mk(4, 5, 1);
        cyc();
        chk("ej_seq_tie", eject_flit, 32'h0000AA42);
        in_n = mk(3, 5, 2);
        in_e = '0;
        in_s = mk(4, 5, 2);
        cyc();
        chk("ej_port_tie", eject_flit, 32'h000129C2);
        idle_in();
        cyc(2);

        // Injection blocked when full, granted into the first hole.
        do_reset();
        in_n = mk(3, 7, 0); in_e = mk(3, 7, 0); in_s = mk(3, 7, 0); in_w = mk(3, 7, 0);
        inject_flit = mk(5, 9, 0);
        inject_req = 1'b1;
        @(negedge clk);
        chk("inj_full_grant", 32'(inject_grant), 32'h0);
        cyc();
        in_e = '0; in_s = '0; in_w = '0;
        @(negedge clk);
        chk("inj_free_grant", 32'(inject_grant), 32'h1);
        cyc();
        idle_in();
        cyc();
        chk("inj_out_s", out_s, 32'h00004AA6);

        // All slots full but one flit ejects: the freed slot takes the injection.
        in_n = mk(3, 5, 0); in_e = mk(3, 7, 0); in_s = mk(3, 7, 0); in_w = mk(3, 7, 0);
        inject_flit = mk(6, 9, 1);
        inject_req = 1'b1;
        @(negedge clk);
        chk("inj_after_eject_grant", 32'(inject_grant), 32'h1);
        cyc();
        idle_in();
        chk("inj_after_eject_valid", 32'(eject_valid), 32'h1);
        cyc(2);

        // Two flits want E: N wins, S deflects to out_n.
        do_reset();
        in_n = mk(3, 7, 0);
        in_s = mk(3, 7, 0);
        cyc();
        idle_in();
        cyc();
        chk("defl_out_e", out_e, 32'h00003992);
        chk("defl_out_n", out_n, 32'h00003982);
        chk("defl_cnt_1", 32'(defl_cnt), 32'h1);

        // Saturation under sustained four-way contention.
        in_n = mk(3, 7, 0); in_e = mk(3, 7, 0); in_s = mk(3, 7, 0); in_w = mk(3, 7, 0);
        for (int i = 0; i < 23000 && m_defl < 65535; i++) cyc();
        cyc(5);
        chk("defl_saturated", 32'(defl_cnt), 32'h0000FFFF);

        // Reset with traffic in flight; outputs stay quiet until two edges after release.
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_e", out_e, 32'h0);
        chk("midrst_defl", 32'(defl_cnt), 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("midrst_quiet_out_e", out_e, 32'h0);
        cyc();
        chk("midrst_resume_out_e", out_e, 32'h00003992);
        idle_in();
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/deflection_router_pipe.md
# deflection_router_pipe

- Parametrised, two-stage pipelined bufferless deflection router for one mesh node: ejection, injection and port allocation.
- Generalises the combinational eject/inject/permute engines:
  - flit field widths are parameters;
  - golden status comes from an internal epoch counter;
  - XY route computation is built in;
  - injection uses a req/grant handshake;
  - there is a deflection statistics counter.
- Sits between the four neighbour links and the local network interface.

## Interface
- FLIT_W, 32, flit width; must be ≥ 7+2·ADDR_W+SEQ_W
- ADDR_W, 4, node address width, even; address = {y, x}, x in the low half
- SEQ_W, 5, in-packet sequence field width
- ROUTER_ADDR, 4'h5, this node's address
- EPOCH, 64, cycles per golden epoch (≥2)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_n/in_e/in_s/in_w  in  FLIT_W  link input flits
- inject_flit  in  FLIT_W  local flit to inject
- inject_req  in  1  injection request
- inject_grant  out  1  combinational; flit consumed at this edge
- out_n/out_e/out_s/out_w  out  FLIT_W  registered link outputs
- eject_flit  out  FLIT_W  registered ejected flit
- eject_valid  out  1  eject_flit valid
- golden_id  out  ADDR_W  current golden source address
- defl_cnt  out  16  saturating deflection count

## Operation
- Flit fields:
  - [0] golden
  - [1] valid
  - [3:2] in-port (N=0, E=1, S=2, W=3)
  - [6:4] out-port (4 = local)
  - [7+:ADDR_W] src
  - [7+ADDR_W+:ADDR_W] dest
  - [7+2·ADDR_W+:SEQ_W] seq
- Flits with [1]=0 are empty; all flit logic ignores them.
- Epoch:
  - Counter runs 0..EPOCH-1.
  - On wrap, golden_id increments modulo 2^ADDR_W.
- Stage 1 (registered at edge):
  - Every input flit's [0] is rewritten to (src==golden_id), using the current golden_id.
  - Eject: among valid inputs with dest==ROUTER_ADDR, pick the winner by priority: golden first, then lowest seq, then lowest port index.
  - Winner goes to eject_flit with [6:4]=4; its slot becomes empty.
  - Inject: inject_grant = inject_req & (at least one empty slot after ejection).
  - On grant, inject_flit fills the lowest-index empty slot, with [3:2] = that slot and [1] forced to 1.
  - [0] of the injected flit is recomputed by the same rule.
- Route computation (per slot):
  - dx>rx → E; dx<rx → W; else dy>ry → S; dy<ry → N.
  - A flit with dest==ROUTER_ADDR that lost ejection has no productive port.
- Stage 2 (registered):
  - Allocate slots in priority order (same key as ejection, in-port as tiebreak).
  - Each flit takes its productive port if free.
  - Otherwise it takes the lowest-index free port (deflection).
  - Output [6:4] = assigned port.
  - Unused outputs are driven all-zero.
  - Every flit that had a productive port but did not get it increments defl_cnt by 1; multiple increments per cycle are summed. defl_cnt saturates at 16'hFFFF.
- Four slots and four outputs guarantee that no flit is dropped.

## Timing
- Reset (async assert, sync-released): all outputs and pipeline registers 0; eject_valid=0, golden_id=0, defl_cnt=0, epoch counter=0.
- Link input → link output: 2 cycles.
- Link input → eject_flit/eject_valid: 1 cycle.
- inject_grant is combinational in the request cycle. Requester holds inject_flit/inject_req until it sees grant; the flit is taken at that rising edge.
- Priority ties, simultaneous golden flits, and injection in the same cycle as ejection are all legal. Ejection is evaluated before the free-slot check, so the freed slot is usable for injection.
- Reset mid-operation: in-flight flits are discarded; no output is asserted until 2 cycles after reset deasserts.

## Test plan
- Config for all scenarios: FLIT_W=32, ADDR_W=4, ROUTER_ADDR=5, EPOCH=4.
- Reset: hold rst_n=0 → all outputs 0. Release, idle 4 cycles → golden_id=1 after the 4th edge, then 2 after 4 more.
- Ejection priority: cycle 0, N (src 0, seq 3) and E (src 2, seq 1) both dest 5, golden_id=0 → eject_valid=1 next cycle with the N flit (golden beats lower seq). E deflects to out_n 2 cycles after input.
- Ejection tiebreak: both inputs non-golden, seq 1 vs 3 → the seq-1 flit is ejected. With equal seq → the lower port index is ejected.
- Injection full: all four inputs valid, none for node 5, inject_req=1 → inject_grant=0. Next cycle with only N valid → grant=1, injected flit appears at the lowest empty slot with [3:2]=1.
- Deflection: N and S both valid, src 3 (non-golden), dest 7 (want E) → higher priority gets out_e; other gets out_n with [6:4]=0; defl_cnt=1.
- Saturation: preload via repeated contention until defl_cnt=16'hFFFF → it stays at FFFF.
